// File: rtl/mem_slave_rw.sv
// Register-file memory slave with one valid/ready request channel for writes and reads.
// Ready back-pressure is either a fixed wait or MIN_WAIT plus a pseudo-random span taken from a 16-bit LFSR.
module mem_slave_rw #(
  parameter int unsigned DATA_W    = 3,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned MIN_WAIT  = 2,
  parameter int unsigned SPAN_W    = 3,
  parameter bit          RAND_EN   = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [15:0]       txn_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic {WAIT, RDY} state_t;

  state_t            state, state_nxt;
  logic [8:0]        wait_cnt, wait_tgt, tgt_nxt;
  logic [15:0]       lfsr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              hs;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT: if (wait_cnt == wait_tgt) state_nxt = RDY;
      RDY:  if (valid)                state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  always_comb begin
    ready = (state == RDY);
    hs    = valid && (state == RDY);
  end

  // The next wait target uses the LFSR value present at the handshake edge, before it steps.
  always_comb begin
    tgt_nxt = 9'(MIN_WAIT);
    if (RAND_EN) tgt_nxt = 9'(MIN_WAIT) + 9'(lfsr[SPAN_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      wait_tgt <= 9'(MIN_WAIT);
      lfsr     <= LFSR_SEED;
      txn_cnt  <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rvalid <= hs && !we;
      if (state == WAIT) begin
        if (wait_cnt == wait_tgt) wait_cnt <= '0;
        else                      wait_cnt <= wait_cnt + 9'd1;
      end
      if (hs) begin
        txn_cnt  <= txn_cnt + 16'd1;
        wait_tgt <= tgt_nxt;
        if (we) mem[addr] <= wdata;
        else    rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: tb/tb_mem_slave_rw.sv
// Bench for mem_slave_rw: a fixed-wait instance and an LFSR-wait instance, both checked every cycle
// against a countdown-based reference model, plus a vector table and hand-written corner sequences.
module tb_mem_slave_rw;
  localparam int DW = 3;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]         valid = '0;
  logic [1:0]         we = '0;
  logic [1:0][AW-1:0] addr = '0;
  logic [1:0][DW-1:0] wdata = '0;

  logic          ready0, ready1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [15:0]   txn0, txn1;
  logic [1:0]          ready, rvalid;
  logic [1:0][DW-1:0]  rdata;
  logic [1:0][15:0]    txn;
  assign ready  = {ready1, ready0};
  assign rvalid = {rvalid1, rvalid0};
  assign rdata  = {rdata1, rdata0};
  assign txn    = {txn1, txn0};

  always #5 clk = ~clk;

  mem_slave_rw #(.DATA_W(DW), .ADDR_W(AW), .MIN_WAIT(4), .SPAN_W(3), .RAND_EN(1'b0), .LFSR_SEED(16'hACE1)) dut_fix (
    .clk(clk), .rst(rst), .valid(valid[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .txn_cnt(txn0));

  mem_slave_rw #(.DATA_W(DW), .ADDR_W(AW), .MIN_WAIT(2), .SPAN_W(3), .RAND_EN(1'b1), .LFSR_SEED(16'hACE1)) dut_rnd (
    .clk(clk), .rst(rst), .valid(valid[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .txn_cnt(txn1));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: ready is a countdown of (target+1) edges, memory is a plain array.
  int unsigned   minw [2] = '{4, 2};
  bit            rnd  [2] = '{1'b0, 1'b1};
  bit            m_ready  [2];
  int            m_left   [2];
  int unsigned   m_lfsr   [2];
  logic [DW-1:0] m_mem    [2][8];
  bit            m_rvalid [2];
  int unsigned   m_rdata  [2];
  int unsigned   m_txn    [2];

  always @(posedge clk) begin
    bit hs;
    int unsigned tgt, fb, taps;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ready[k] = 1'b0; m_left[k] = minw[k] + 1; m_lfsr[k] = 16'hACE1;
        m_rvalid[k] = 1'b0; m_rdata[k] = 0; m_txn[k] = 0;
        for (int a = 0; a < 8; a++) m_mem[k][a] = '0;
      end else begin
        hs = valid[k] && m_ready[k];
        m_rvalid[k] = hs && !we[k];
        if (hs && !we[k]) m_rdata[k] = m_mem[k][addr[k]];
        if (hs && we[k])  m_mem[k][addr[k]] = wdata[k];
        if (hs) begin
          m_txn[k] = (m_txn[k] + 1) % 65536;
          tgt = minw[k] + (rnd[k] ? (m_lfsr[k] % 8) : 0);
          m_left[k] = tgt + 1;
          m_ready[k] = 1'b0;
        end else if (!m_ready[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) m_ready[k] = 1'b1;
        end
        taps = m_lfsr[k] & 32'hB400;
        fb = $countones(taps) % 2;
        m_lfsr[k] = (m_lfsr[k] * 2 + fb) % 65536;
      end
    end
  end

  bit prev_r1 = 1'b0;
  bit gap_arm = 1'b0;
  int gap = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("ready",  k, ready[k],  m_ready[k]);
        chk("rvalid", k, rvalid[k], m_rvalid[k]);
        chk("rdata",  k, rdata[k],  m_rdata[k]);
        chk("txn_cnt", k, txn[k],   m_txn[k]);
      end
      if (rst) gap_arm = 1'b0;
      else if (prev_r1 && !ready[1]) begin gap_arm = 1'b1; gap = 1; end
      else if (gap_arm && !ready[1]) gap++;
      else if (gap_arm && ready[1]) begin
        checks++;
        if (gap < 3 || gap > 10) begin
          errors++;
          $display("FAIL gap dut1 got %0d expected 3..10", gap);
        end
        gap_arm = 1'b0;
      end
      prev_r1 = ready[1];
    end
  end

  task automatic wait_ready(input int k);
    int n = 0;
    while (!ready[k] && n < 40) begin @(negedge clk); n++; end
    if (!ready[k]) begin
      checks++; errors++;
      $display("FAIL wait_ready dut%0d got 0 expected 1 within 40 cycles", k);
    end
  endtask

  typedef struct {
    bit v; bit w; logic [AW-1:0] a; logic [DW-1:0] d;
    bit er; bit erv; logic [DW-1:0] erd; int et;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int j = 0; j < 4; j++) tbl[j] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, 3, 5, 0, 0, 0, 1};
    for (int j = 6; j < 10; j++) tbl[j] = '{1, 1, 3, 2, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 0, 1};
    tbl[11] = '{1, 0, 3, 0, 0, 1, 5, 2};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 5, 2};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Fixed-wait table: 5 edges to ready, write 3<-5, waits ignore valid, read back.
    for (int j = 0; j < 13; j++) begin
      rst = 1'b0;
      valid[0] = tbl[j].v; we[0] = tbl[j].w; addr[0] = tbl[j].a; wdata[0] = tbl[j].d;
      @(negedge clk);
      chk("tbl_ready",  j, ready[0],  tbl[j].er);
      chk("tbl_rvalid", j, rvalid[0], tbl[j].erv);
      chk("tbl_rdata",  j, rdata[0],  tbl[j].erd);
      chk("tbl_txn",    j, txn[0],    tbl[j].et);
    end

    // valid held through reset release: exactly one write at the first ready cycle.
    rst = 1'b1;
    valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 7; wdata[0] = 6;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready(0);
    @(negedge clk);
    valid[0] = 1'b0;
    chk("held_txn", 0, txn[0], 1);
    chk("held_ready", 0, ready[0], 0);
    wait_ready(0);
    chk("held_txn_later", 0, txn[0], 1);
    valid[0] = 1'b1; we[0] = 1'b0; addr[0] = 7;
    @(negedge clk);
    valid[0] = 1'b0;
    chk("held_rvalid", 0, rvalid[0], 1);
    chk("held_rdata", 0, rdata[0], 6);

    // Reset landing on a handshake edge: no write, everything cleared.
    wait_ready(0);
    valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 1; wdata[0] = 7;
    rst = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    chk("rst_ready", 0, ready[0], 0);
    chk("rst_txn", 0, txn[0], 0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(0);
    valid[0] = 1'b1; we[0] = 1'b0; addr[0] = 1;
    @(negedge clk);
    valid[0] = 1'b0;
    chk("rst_rvalid", 0, rvalid[0], 1);
    chk("rst_rdata", 0, rdata[0], 0);

    // Random traffic on both instances against the model.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        valid[k] = ($urandom_range(0, 2) != 0);
        we[k]    = $urandom_range(0, 1) != 0;
        addr[k]  = AW'($urandom_range(0, 7));
        wdata[k] = DW'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    valid = '0;
    chk("rand_txn_ge20", 1, (txn[1] >= 16'd20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
